// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width and branch-predictor counter encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_RST      = WNT;
  localparam bp_ctr_e BP_CTR_ALLOC_BR = WT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction-counter next-state function.
module bp_sat_counter
  import riscv_pkg::*;
(
  input  bp_ctr_e ctr_i,
  input  logic    inc_i,
  input  logic    dec_i,
  input  logic    set_st_i,
  output bp_ctr_e ctr_nxt_o
);

  always_comb begin
    ctr_nxt_o = ctr_i;
    if (set_st_i) begin
      ctr_nxt_o = ST;
    end else if (inc_i && (ctr_i != ST)) begin
      ctr_nxt_o = bp_ctr_e'(2'(ctr_i + 2'd1));
    end else if (dec_i && (ctr_i != SNT)) begin
      ctr_nxt_o = bp_ctr_e'(2'(ctr_i - 2'd1));
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: fetch-time prediction,
// execute-time training, misprediction detection and saturating statistics.
module riscv_branch_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  lk_pc_i,
  output logic             lk_taken_o,
  output logic [XLEN-1:0]  lk_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_is_jump_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  bp_ctr_e            r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CNT_W-1:0]   r_br_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_lk_taken;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic               w_upd_br;
  logic               w_wr_en;
  logic               w_tgt_en;
  logic               w_mispredict;
  bp_ctr_e            w_ctr_cur;
  bp_ctr_e            w_ctr_nxt;

  // Fetch-side lookup
  assign w_lk_idx    = lk_pc_i[IDX_W+1:2];
  assign w_lk_tag    = lk_pc_i[XLEN-1:IDX_W+2];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign lk_taken_o  = w_lk_taken;
  assign lk_target_o = w_lk_taken ? r_target[w_lk_idx] : (lk_pc_i + XLEN'(4));

  // Execute-side resolution; suppressed while reset is held
  assign w_mispredict = rstn_i && upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_pred_taken_i &&
                          (upd_target_i != upd_pred_target_i)));
  assign mispredict_o  = w_mispredict;
  assign redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + XLEN'(4));

  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_br  = !upd_is_jump_i;

  // A miss writes only when taken; a hit always retrains the counter
  assign w_wr_en  = upd_valid_i && (w_upd_hit || upd_taken_i);
  assign w_tgt_en = upd_valid_i && (upd_taken_i || (w_upd_hit && upd_is_jump_i));

  // Allocation seeds the counter at WT; jumps force ST either way
  assign w_ctr_cur = w_upd_hit ? r_ctr[w_upd_idx] : BP_CTR_ALLOC_BR;

  bp_sat_counter u_sat_counter (
    .ctr_i     (w_ctr_cur),
    .inc_i     (w_upd_hit && w_upd_br && upd_taken_i),
    .dec_i     (w_upd_hit && w_upd_br && !upd_taken_i),
    .set_st_i  (upd_is_jump_i),
    .ctr_nxt_o (w_ctr_nxt)
  );

  // Entry storage, training and statistics; clear wins over update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid    <= '0;
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_ctr[i]    <= BP_CTR_RST;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (clear_i) begin
      r_valid    <= '0;
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_ctr[i] <= BP_CTR_RST;
      end
    end else begin
      if (w_wr_en) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_tag[w_upd_idx]   <= w_upd_tag;
        r_ctr[w_upd_idx]   <= w_ctr_nxt;
      end
      if (w_tgt_en) begin
        r_target[w_upd_idx] <= upd_target_i;
      end
      if (upd_valid_i && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign br_cnt_o   = r_br_cnt;
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Randomized and directed bench for riscv_branch_predictor against an array-based model.
module tb_riscv_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int          IDXB    = $clog2(ENTRIES);
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             clear_i;
  logic [31:0]      lk_pc_i;
  logic             lk_taken_o;
  logic [31:0]      lk_target_o;
  logic             upd_valid_i;
  logic [31:0]      upd_pc_i;
  logic             upd_is_jump_i;
  logic             upd_taken_i;
  logic [31:0]      upd_target_i;
  logic             upd_pred_taken_i;
  logic [31:0]      upd_pred_target_i;
  logic             mispredict_o;
  logic [31:0]      redirect_pc_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  // Model: entry state as plain integers, strength 0..3 (>=2 predicts taken)
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_str [ENTRIES];
  int          m_br;
  int          m_miss;

  riscv_branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i),
    .lk_pc_i(lk_pc_i), .lk_taken_o(lk_taken_o), .lk_target_o(lk_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_jump_i(upd_is_jump_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_pred_taken_i(upd_pred_taken_i), .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDXB + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_str[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_v[i] = 1'b0; m_str[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_br = 0; m_miss = 0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, advance the model
  task automatic cyc(input bit clr, input logic [31:0] lpc, input bit uv,
                     input logic [31:0] upc, input bit uj, input bit ut,
                     input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
    bit e_mis;
    int k;
    clear_i = clr; lk_pc_i = lpc; upd_valid_i = uv; upd_pc_i = upc;
    upd_is_jump_i = uj; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt;
    #1;
    e_mis = uv && ((ut != upt) || (ut && upt && (utgt != uptgt)));
    chk("lk_taken", 32'(lk_taken_o), 32'(m_taken(lpc)));
    chk("lk_target", lk_target_o, m_target(lpc));
    chk("mispredict", 32'(mispredict_o), 32'(e_mis));
    if (e_mis) chk("redirect", redirect_pc_o, ut ? utgt : upc + 32'd4);
    chk("br_cnt", 32'(br_cnt_o), 32'(m_br));
    chk("miss_cnt", 32'(miss_cnt_o), 32'(m_miss));
    @(posedge clk_i);
    k = slot(upc);
    if (clr) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin m_v[i] = 1'b0; m_str[i] = 1; end
      m_br = 0; m_miss = 0;
    end else if (uv) begin
      if (m_br < CMAX) m_br++;
      if (e_mis && m_miss < CMAX) m_miss++;
      if (m_hit(upc)) begin
        if (uj) begin
          m_str[k] = 3; m_tgt[k] = utgt;
        end else if (ut) begin
          m_str[k] = (m_str[k] < 3) ? m_str[k] + 1 : 3; m_tgt[k] = utgt;
        end else begin
          m_str[k] = (m_str[k] > 0) ? m_str[k] - 1 : 0;
        end
      end else if (ut) begin
        m_v[k] = 1'b1; m_tag[k] = tag_of(upc); m_tgt[k] = utgt; m_str[k] = uj ? 3 : 2;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle_upd();
    upd_valid_i = 1'b0; clear_i = 1'b0; upd_is_jump_i = 1'b0; upd_taken_i = 1'b0;
    upd_pc_i = '0; upd_target_i = '0; upd_pred_taken_i = 1'b0; upd_pred_target_i = '0;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFC0 | (32'($urandom_range(0, 15)) << 2);
    else pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    return pc;
  endfunction

  task automatic rnd_cycle(input bit allow_clr);
    logic [31:0] upc, lpc, tgt, ptgt;
    bit uj, ut, pt, clr;
    upc  = rnd_pc();
    lpc  = ($urandom_range(0, 3) == 0) ? upc : rnd_pc();
    uj   = ($urandom_range(0, 4) == 0);
    ut   = uj ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
    tgt  = ($urandom_range(0, 1) == 1) ? m_tgt[slot(upc)] : rnd_pc();
    pt   = m_taken(upc);
    ptgt = m_target(upc);
    if ($urandom_range(0, 7) == 0) pt = ~pt;
    if ($urandom_range(0, 7) == 0) ptgt = rnd_pc();
    clr  = allow_clr && ($urandom_range(0, 59) == 0);
    cyc(clr, lpc, ($urandom_range(0, 5) != 0), upc, uj, ut, tgt, pt, ptgt);
  endtask

  initial begin
    rstn_i = 1'b0; lk_pc_i = 32'h100; idle_upd();
    m_reset();
    #1;
    upd_valid_i = 1'b1; upd_taken_i = 1'b1; upd_target_i = 32'h80; upd_pc_i = 32'h100;
    #1;
    chk("rst_mispredict", 32'(mispredict_o), 32'd0);
    idle_upd();
    @(negedge clk_i); @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    chk("rst_taken", 32'(lk_taken_o), 32'd0);
    chk("rst_target", lk_target_o, 32'h104);
    chk("rst_br", 32'(br_cnt_o), 32'd0);
    chk("rst_miss", 32'(miss_cnt_o), 32'd0);

    // Taken branch allocation with mispredict, then WT lookup
    cyc(0, 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    idle_upd(); lk_pc_i = 32'h100; #1;
    chk("alloc_taken", 32'(lk_taken_o), 32'd1);
    chk("alloc_target", lk_target_o, 32'h80);
    chk("alloc_miss", 32'(miss_cnt_o), 32'd1);
    #1;

    // Three not-taken updates walk the counter down and saturate
    for (int i = 0; i < 3; i++) cyc(0, 32'h100, 1, 32'h100, 0, 0, 32'h0, m_taken(32'h100), m_target(32'h100));
    idle_upd(); lk_pc_i = 32'h100; #1;
    chk("sat_nt_taken", 32'(lk_taken_o), 32'd0);
    chk("sat_nt_target", lk_target_o, 32'h104);
    #1;

    // JAL, then clear colliding with a taken update
    cyc(0, 32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 32'h204);
    cyc(1, 32'h200, 1, 32'h300, 0, 1, 32'h500, 0, 32'h304);
    idle_upd();
    lk_pc_i = 32'h200; #1; chk("clr_jal", 32'(lk_taken_o), 32'd0);
    lk_pc_i = 32'h300; #1; chk("clr_upd", 32'(lk_taken_o), 32'd0);
    chk("clr_br", 32'(br_cnt_o), 32'd0);
    chk("clr_miss", 32'(miss_cnt_o), 32'd0);
    #1;

    // Aliasing on index 0
    cyc(0, 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    cyc(0, 32'h100, 1, 32'h140, 0, 1, 32'h90, 0, 32'h144);
    idle_upd();
    lk_pc_i = 32'h100; #1; chk("alias_old", 32'(lk_taken_o), 32'd0);
    lk_pc_i = 32'h140; #1; chk("alias_new", lk_target_o, 32'h90);
    #1;

    // Same-cycle update and lookup returns old prediction
    cyc(0, 32'h100, 1, 32'h100, 0, 1, 32'h88, 0, 32'h104);
    idle_upd(); lk_pc_i = 32'h100; #1;
    chk("bypass_next", lk_target_o, 32'h88);
    #1;

    // Wrap of pc+4 at the top of the address space
    idle_upd(); lk_pc_i = 32'hFFFF_FFFC; #1;
    chk("wrap_lk", lk_target_o, 32'h0);
    upd_valid_i = 1'b1; upd_pc_i = 32'hFFFF_FFFC; upd_pred_taken_i = 1'b1; upd_pred_target_i = 32'h40;
    #1; chk("wrap_redirect", redirect_pc_o, 32'h0);
    idle_upd();
    @(negedge clk_i);

    // Reset during a training edge leaves nothing behind
    lk_pc_i = 32'h3C0; upd_valid_i = 1'b1; upd_pc_i = 32'h3C0; upd_taken_i = 1'b1;
    upd_target_i = 32'h700;
    #2 rstn_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    idle_upd(); rstn_i = 1'b1; m_reset();
    #1;
    chk("rst_abort", 32'(lk_taken_o), 32'd0);
    chk("rst_abort_br", 32'(br_cnt_o), 32'd0);
    @(negedge clk_i);

    for (int i = 0; i < 1500; i++) rnd_cycle(1'b1);

    // Long run without clear drives br_cnt into saturation
    for (int i = 0; i < 80; i++) rnd_cycle(1'b0);
    cyc(0, 32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80);
    idle_upd(); #1;
    chk("br_sat", 32'(br_cnt_o), 32'(CMAX));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
